alu_op_sequencer: RTL and testbench



---
 rtl/alu_op_sequencer.sv | 179 +++++++++++++++++
 tb/tb_alu_op_sequencer.sv | 319 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_op_sequencer.sv
// alu_op_sequencer: command-side sequencer for a 16-bit combinational bitwise
// unit. Accepts one op over cmd valid/ready, drives the registered operand
// bus, waits SETTLE cycles, captures the selected unit result and returns it
// over rsp valid/ready with zero/error flags.
// Optional build macro: ALU_SEQ_CHECK_EN enables an internal recompute of the
// selected op at capture time; a mismatch flags rsp_err and sets sticky
// chk_fail.
module alu_op_sequencer #(
  parameter int WIDTH  = 16,
  parameter int SETTLE = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [2:0]       cmd_op,
  input  logic [WIDTH-1:0] cmd_a,
  input  logic [WIDTH-1:0] cmd_b,
  output logic [WIDTH-1:0] opnd_a,
  output logic [WIDTH-1:0] opnd_b,
  input  logic [WIDTH-1:0] res_and,
  input  logic [WIDTH-1:0] res_or,
  input  logic [WIDTH-1:0] res_nand,
  input  logic [WIDTH-1:0] res_nor,
  input  logic [WIDTH-1:0] res_xor,
  input  logic [WIDTH-1:0] res_xnor,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_data,
  output logic             rsp_zero,
  output logic             rsp_err,
  output logic             busy,
  output logic             chk_fail
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SETTLE = 2'd1,
    S_RESP   = 2'd2
  } state_t;

  // Counter preload: the last SETTLE cycle is the one where the count is 0.
  localparam logic [3:0] CNT_INIT = 4'(SETTLE - 1);

  state_t           r_state;
  state_t           w_state_next;
  logic [2:0]       r_op;
  logic [3:0]       r_cnt;
  logic [WIDTH-1:0] r_opnd_a;
  logic [WIDTH-1:0] r_opnd_b;
  logic [WIDTH-1:0] r_rsp_data;
  logic             r_rsp_zero;
  logic             r_rsp_err;
  logic             w_op_legal;
  logic             w_accept;
  logic             w_capture;
  logic             w_chk_mis;
  logic [WIDTH-1:0] w_sel;

  assign w_op_legal = (cmd_op <= 3'd5);
  assign w_accept   = cmd_valid & cmd_ready;

  // State register.
  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_next;
  end

  // Next-state and handshake control; a response handshake in RESP can take
  // a new command on the same edge, exactly as from IDLE.
  always_comb begin
    w_state_next = r_state;
    cmd_ready    = 1'b0;
    rsp_valid    = 1'b0;
    w_capture    = 1'b0;
    case (r_state)
      S_IDLE: begin
        cmd_ready = 1'b1;
        if (cmd_valid) w_state_next = w_op_legal ? S_SETTLE : S_RESP;
      end
      S_SETTLE: begin
        if (r_cnt == 4'd0) begin
          w_capture    = 1'b1;
          w_state_next = S_RESP;
        end
      end
      S_RESP: begin
        rsp_valid = 1'b1;
        cmd_ready = rsp_ready;
        if (rsp_ready) begin
          if (cmd_valid) w_state_next = w_op_legal ? S_SETTLE : S_RESP;
          else           w_state_next = S_IDLE;
        end
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  // Select the unit output that matches the latched opcode.
  always_comb begin
    case (r_op)
      3'd0:    w_sel = res_and;
      3'd1:    w_sel = res_or;
      3'd2:    w_sel = res_nand;
      3'd3:    w_sel = res_nor;
      3'd4:    w_sel = res_xor;
      3'd5:    w_sel = res_xnor;
      default: w_sel = '0;
    endcase
  end

`ifdef ALU_SEQ_CHECK_EN
  logic [WIDTH-1:0] w_ref;
  logic             r_chk_fail;

  // Independent recompute of the selected op from the operand bus.
  always_comb begin
    case (r_op)
      3'd0:    w_ref = r_opnd_a & r_opnd_b;
      3'd1:    w_ref = r_opnd_a | r_opnd_b;
      3'd2:    w_ref = ~(r_opnd_a & r_opnd_b);
      3'd3:    w_ref = ~(r_opnd_a | r_opnd_b);
      3'd4:    w_ref = r_opnd_a ^ r_opnd_b;
      3'd5:    w_ref = ~(r_opnd_a ^ r_opnd_b);
      default: w_ref = '0;
    endcase
  end

  assign w_chk_mis = w_capture & (w_ref != w_sel);

  // Sticky check failure, cleared only by reset.
  always_ff @(posedge clk) begin
    if (rst)            r_chk_fail <= 1'b0;
    else if (w_chk_mis) r_chk_fail <= 1'b1;
  end

  assign chk_fail = r_chk_fail;
`else
  assign w_chk_mis = 1'b0;
  assign chk_fail  = 1'b0;
`endif

  // Operand bus, settle counter and response registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_op       <= 3'd0;
      r_cnt      <= 4'd0;
      r_opnd_a   <= '0;
      r_opnd_b   <= '0;
      r_rsp_data <= '0;
      r_rsp_zero <= 1'b1;
      r_rsp_err  <= 1'b0;
    end else if (w_accept && w_op_legal) begin
      r_op     <= cmd_op;
      r_opnd_a <= cmd_a;
      r_opnd_b <= cmd_b;
      r_cnt    <= CNT_INIT;
    end else if (w_accept) begin
      // Illegal opcode: operand bus untouched, immediate error response.
      r_rsp_data <= '0;
      r_rsp_zero <= 1'b1;
      r_rsp_err  <= 1'b1;
    end else if (w_capture) begin
      r_rsp_data <= w_sel;
      r_rsp_zero <= (w_sel == '0);
      r_rsp_err  <= w_chk_mis;
    end else if (r_state == S_SETTLE) begin
      r_cnt <= r_cnt - 4'd1;
    end
  end

  assign opnd_a   = r_opnd_a;
  assign opnd_b   = r_opnd_b;
  assign rsp_data = r_rsp_data;
  assign rsp_zero = r_rsp_zero;
  assign rsp_err  = r_rsp_err;
  assign busy     = (r_state != S_IDLE);

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Testbench for alu_op_sequencer: two instances (SETTLE=1 and SETTLE=3), each
// with a behavioural model of the bitwise unit. Table vectors, random
// transactions against a reference model, and hand-written sequences for
// backpressure with same-edge handshakes and reset during SETTLE.
// Define ALU_SEQ_CHECK_EN for both RTL and bench to exercise the self-check.
module tb_alu_op_sequencer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cmd_valid [2];
  logic        cmd_ready [2];
  logic [2:0]  cmd_op    [2];
  logic [15:0] cmd_a     [2];
  logic [15:0] cmd_b     [2];
  logic [15:0] opnd_a    [2];
  logic [15:0] opnd_b    [2];
  logic [15:0] res_and   [2];
  logic [15:0] res_or    [2];
  logic [15:0] res_nand  [2];
  logic [15:0] res_nor   [2];
  logic [15:0] res_xor   [2];
  logic [15:0] res_xnor  [2];
  logic        rsp_valid [2];
  logic        rsp_ready [2];
  logic [15:0] rsp_data  [2];
  logic        rsp_zero  [2];
  logic        rsp_err   [2];
  logic        busy      [2];
  logic        chk_fail  [2];
  logic        corrupt   [2];

  int n_checks = 0;
  int n_fail   = 0;

  // Model state: expected operand bus and sticky check flag per instance.
  logic [15:0] m_a   [2];
  logic [15:0] m_b   [2];
  logic        m_chk [2];

  always #5 clk = ~clk;

  alu_op_sequencer #(.WIDTH(16), .SETTLE(1)) u_dut0 (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid[0]), .cmd_ready(cmd_ready[0]), .cmd_op(cmd_op[0]),
    .cmd_a(cmd_a[0]), .cmd_b(cmd_b[0]),
    .opnd_a(opnd_a[0]), .opnd_b(opnd_b[0]),
    .res_and(res_and[0]), .res_or(res_or[0]), .res_nand(res_nand[0]),
    .res_nor(res_nor[0]), .res_xor(res_xor[0]), .res_xnor(res_xnor[0]),
    .rsp_valid(rsp_valid[0]), .rsp_ready(rsp_ready[0]), .rsp_data(rsp_data[0]),
    .rsp_zero(rsp_zero[0]), .rsp_err(rsp_err[0]), .busy(busy[0]),
    .chk_fail(chk_fail[0])
  );

  alu_op_sequencer #(.WIDTH(16), .SETTLE(3)) u_dut1 (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid[1]), .cmd_ready(cmd_ready[1]), .cmd_op(cmd_op[1]),
    .cmd_a(cmd_a[1]), .cmd_b(cmd_b[1]),
    .opnd_a(opnd_a[1]), .opnd_b(opnd_b[1]),
    .res_and(res_and[1]), .res_or(res_or[1]), .res_nand(res_nand[1]),
    .res_nor(res_nor[1]), .res_xor(res_xor[1]), .res_xnor(res_xnor[1]),
    .rsp_valid(rsp_valid[1]), .rsp_ready(rsp_ready[1]), .rsp_data(rsp_data[1]),
    .rsp_zero(rsp_zero[1]), .rsp_err(rsp_err[1]), .busy(busy[1]),
    .chk_fail(chk_fail[1])
  );

  // Behavioural bitwise unit per instance; corrupt flips res_and bit 0.
  for (genvar gi = 0; gi < 2; gi++) begin : g_unit
    assign res_and[gi]  = (opnd_a[gi] & opnd_b[gi]) ^ {15'd0, corrupt[gi]};
    assign res_or[gi]   = opnd_a[gi] | opnd_b[gi];
    assign res_nand[gi] = ~(opnd_a[gi] & opnd_b[gi]);
    assign res_nor[gi]  = ~(opnd_a[gi] | opnd_b[gi]);
    assign res_xor[gi]  = opnd_a[gi] ^ opnd_b[gi];
    assign res_xnor[gi] = ~(opnd_a[gi] ^ opnd_b[gi]);
  end

  typedef struct {
    logic [2:0]  op;
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] data;
    logic        zero;
    logic        err;
  } vec_t;

  vec_t vecs [8];

  function automatic int settle_of(input int d);
    return (d == 0) ? 1 : 3;
  endfunction

  // Reference result: the named bitwise operation, or 0 for illegal opcodes.
  function automatic logic [15:0] ref_res(input logic [2:0] op, input logic [15:0] a,
                                          input logic [15:0] b);
    case (op)
      3'd0:    return a & b;
      3'd1:    return a | b;
      3'd2:    return ~(a & b);
      3'd3:    return ~(a | b);
      3'd4:    return a ^ b;
      3'd5:    return ~(a ^ b);
      default: return 16'h0000;
    endcase
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, required %h", name, act, exp);
    end
  endtask

  // One full transaction on instance d: send, measure latency, check the
  // response, optionally hold rsp_ready low, then drain.
  task automatic run_txn(input int d, input logic [2:0] op, input logic [15:0] a,
                         input logic [15:0] b, input int hold, input logic [15:0] e_data,
                         input logic e_zero, input logic e_err);
    int lat;
    int exp_lat;
    logic legal;
    legal   = (op < 3'd6);
    exp_lat = legal ? settle_of(d) + 1 : 1;
    if (legal) begin
      m_a[d] = a;
      m_b[d] = b;
    end
    @(negedge clk);
    check("cmd_ready_idle", 32'(cmd_ready[d]), 32'd1);
    cmd_valid[d] = 1'b1;
    cmd_op[d]    = op;
    cmd_a[d]     = a;
    cmd_b[d]     = b;
    @(negedge clk);
    cmd_valid[d] = 1'b0;
    lat = 1;
    while (!rsp_valid[d] && lat < 50) begin
      @(negedge clk);
      lat++;
    end
    check("latency", 32'(lat), 32'(exp_lat));
    check("rsp_data", 32'(rsp_data[d]), 32'(e_data));
    check("rsp_zero", 32'(rsp_zero[d]), 32'(e_zero));
    check("rsp_err", 32'(rsp_err[d]), 32'(e_err));
    check("opnd_a", 32'(opnd_a[d]), 32'(m_a[d]));
    check("opnd_b", 32'(opnd_b[d]), 32'(m_b[d]));
    check("chk_fail", 32'(chk_fail[d]), 32'(m_chk[d]));
    repeat (hold) begin
      @(negedge clk);
      check("hold_valid", 32'(rsp_valid[d]), 32'd1);
      check("hold_data", 32'(rsp_data[d]), 32'(e_data));
    end
    rsp_ready[d] = 1'b1;
    @(negedge clk);
    rsp_ready[d] = 1'b0;
    check("drain_valid", 32'(rsp_valid[d]), 32'd0);
    check("drain_busy", 32'(busy[d]), 32'd0);
    $display("txn d=%0d op=%0d a=%h b=%h data=%h zero=%0d err=%0d lat=%0d",
             d, op, a, b, rsp_data[d], rsp_zero[d], rsp_err[d], lat);
  endtask

  task automatic check_reset_state(input int d);
    check("rst_cmd_ready", 32'(cmd_ready[d]), 32'd1);
    check("rst_rsp_valid", 32'(rsp_valid[d]), 32'd0);
    check("rst_busy", 32'(busy[d]), 32'd0);
    check("rst_opnd_a", 32'(opnd_a[d]), 32'd0);
    check("rst_opnd_b", 32'(opnd_b[d]), 32'd0);
    check("rst_rsp_zero", 32'(rsp_zero[d]), 32'd1);
    check("rst_rsp_data", 32'(rsp_data[d]), 32'd0);
    check("rst_rsp_err", 32'(rsp_err[d]), 32'd0);
    check("rst_chk_fail", 32'(chk_fail[d]), 32'd0);
  endtask

  task automatic reset_model();
    for (int d = 0; d < 2; d++) begin
      m_a[d]   = 16'h0000;
      m_b[d]   = 16'h0000;
      m_chk[d] = 1'b0;
    end
  endtask

  // Watchdog so the run always ends.
  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [2:0]  r_op_v;
    logic [15:0] r_a;
    logic [15:0] r_b;
    logic [15:0] r_data;
    int          r_d;

    vecs[0] = '{op: 3'd0, a: 16'hF0F0, b: 16'hFF00, data: 16'hF000, zero: 1'b0, err: 1'b0};
    vecs[1] = '{op: 3'd4, a: 16'h1234, b: 16'h1234, data: 16'h0000, zero: 1'b1, err: 1'b0};
    vecs[2] = '{op: 3'd5, a: 16'h1234, b: 16'h1234, data: 16'hFFFF, zero: 1'b0, err: 1'b0};
    vecs[3] = '{op: 3'd1, a: 16'hF0F0, b: 16'h0F0F, data: 16'hFFFF, zero: 1'b0, err: 1'b0};
    vecs[4] = '{op: 3'd2, a: 16'hFFFF, b: 16'hFFFF, data: 16'h0000, zero: 1'b1, err: 1'b0};
    vecs[5] = '{op: 3'd3, a: 16'h0A00, b: 16'h00A0, data: 16'hF55F, zero: 1'b0, err: 1'b0};
    vecs[6] = '{op: 3'd6, a: 16'hAAAA, b: 16'h5555, data: 16'h0000, zero: 1'b1, err: 1'b1};
    vecs[7] = '{op: 3'd7, a: 16'h0001, b: 16'h0002, data: 16'h0000, zero: 1'b1, err: 1'b1};

    for (int d = 0; d < 2; d++) begin
      cmd_valid[d] = 1'b0;
      cmd_op[d]    = 3'd0;
      cmd_a[d]     = 16'h0000;
      cmd_b[d]     = 16'h0000;
      rsp_ready[d] = 1'b0;
      corrupt[d]   = 1'b0;
    end
    reset_model();

    // Reset held for two cycles.
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    check_reset_state(0);
    check_reset_state(1);

    // Table vectors on both instances.
    for (int d = 0; d < 2; d++) begin
      for (int i = 0; i < 8; i++) begin
        run_txn(d, vecs[i].op, vecs[i].a, vecs[i].b, i % 2,
                vecs[i].data, vecs[i].zero, vecs[i].err);
      end
    end

    // Randomized transactions against the reference model.
    for (int i = 0; i < 40; i++) begin
      r_d    = int'($urandom_range(0, 1));
      r_op_v = 3'($urandom_range(0, 7));
      r_a    = 16'($urandom);
      r_b    = 16'($urandom);
      if (i % 8 == 0) r_b = r_a;
      r_data = ref_res(r_op_v, r_a, r_b);
      run_txn(r_d, r_op_v, r_a, r_b, int'($urandom_range(0, 2)),
              r_data, (r_data == 16'h0000), (r_op_v > 3'd5));
    end

    // Backpressure for 5 cycles with a pending command, then both handshakes
    // on the same edge (instance 0, SETTLE=1).
    @(negedge clk);
    cmd_valid[0] = 1'b1;
    cmd_op[0]    = 3'd1;
    cmd_a[0]     = 16'h00FF;
    cmd_b[0]     = 16'h0F00;
    @(negedge clk);
    cmd_valid[0] = 1'b0;
    @(negedge clk);
    check("bp_first_valid", 32'(rsp_valid[0]), 32'd1);
    cmd_valid[0] = 1'b1;
    cmd_op[0]    = 3'd4;
    cmd_a[0]     = 16'hFF00;
    cmd_b[0]     = 16'h0FF0;
    repeat (5) begin
      @(negedge clk);
      check("bp_valid", 32'(rsp_valid[0]), 32'd1);
      check("bp_cmd_ready", 32'(cmd_ready[0]), 32'd0);
      check("bp_data", 32'(rsp_data[0]), 32'h0FFF);
      check("bp_opnd_a", 32'(opnd_a[0]), 32'h00FF);
    end
    rsp_ready[0] = 1'b1;
    @(negedge clk);
    rsp_ready[0] = 1'b0;
    cmd_valid[0] = 1'b0;
    check("same_edge_busy", 32'(busy[0]), 32'd1);
    check("same_edge_valid", 32'(rsp_valid[0]), 32'd0);
    check("same_edge_opnd_a", 32'(opnd_a[0]), 32'hFF00);
    @(negedge clk);
    check("second_valid", 32'(rsp_valid[0]), 32'd1);
    check("second_data", 32'(rsp_data[0]), 32'hF0F0);
    check("second_zero", 32'(rsp_zero[0]), 32'd0);
    rsp_ready[0] = 1'b1;
    @(negedge clk);
    rsp_ready[0] = 1'b0;
    check("second_drain", 32'(busy[0]), 32'd0);
    $display("txn d=0 backpressure + same-edge handshake done");
    m_a[0] = 16'hFF00;
    m_b[0] = 16'h0FF0;

`ifdef ALU_SEQ_CHECK_EN
    // Corrupted unit output: error response and sticky chk_fail.
    corrupt[0] = 1'b1;
    m_chk[0]   = 1'b1;
    run_txn(0, 3'd0, 16'hFFFF, 16'h0001, 0, 16'h0000, 1'b1, 1'b1);
    corrupt[0] = 1'b0;
    run_txn(0, 3'd1, 16'h1200, 16'h0034, 0, 16'h1234, 1'b0, 1'b0);
`endif

    // Reset during SETTLE (instance 1, SETTLE=3): no response afterwards.
    @(negedge clk);
    cmd_valid[1] = 1'b1;
    cmd_op[1]    = 3'd2;
    cmd_a[1]     = 16'h1111;
    cmd_b[1]     = 16'h2222;
    @(negedge clk);
    cmd_valid[1] = 1'b0;
    check("settle_busy", 32'(busy[1]), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    reset_model();
    check_reset_state(1);
    check_reset_state(0);
    repeat (6) begin
      @(negedge clk);
      check("no_rsp_after_rst", 32'(rsp_valid[1]), 32'd0);
    end
    $display("txn d=1 reset during SETTLE done");

    // Normal operation resumes after reset.
    run_txn(1, 3'd0, 16'hF0F0, 16'hFF00, 0, 16'hF000, 1'b0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
